// File: rtl/wb_sram_target.sv
// Wishbone classic target backed by a word-wide SRAM array.
// Registered response with programmable wait states, byte-lane writes and error
// termination for out-of-range or misaligned accesses.
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous active-low reset
//   adr          byte address (bits in ADR_MASK are ignored)
//   dat_w/dat_r  write data / read data (dat_r is 0 outside a read ack)
//   cyc,stb,we   Wishbone cycle, strobe, write enable
//   sel          byte lane enables
//   ack,err      one-cycle normal / error termination
module wb_sram_target #(
    parameter int                       WB_ADDR_WIDTH  = 32,
    parameter int                       WB_DATA_WIDTH  = 32,
    parameter int                       MEM_DEPTH_LOG2 = 10,
    parameter logic [WB_ADDR_WIDTH-1:0] ADR_MASK       = 32'hF000_0000,
    parameter int                       WAIT_STATES    = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [WB_ADDR_WIDTH-1:0]   adr,
    input  logic [WB_DATA_WIDTH-1:0]   dat_w,
    output logic [WB_DATA_WIDTH-1:0]   dat_r,
    input  logic                       cyc,
    input  logic                       stb,
    input  logic                       we,
    input  logic [WB_DATA_WIDTH/8-1:0] sel,
    output logic                       ack,
    output logic                       err
);

    localparam int LANES = WB_DATA_WIDTH / 8;
    localparam int DEPTH = 1 << MEM_DEPTH_LOG2;

    localparam logic [WB_ADDR_WIDTH-1:0] MEM_BYTES =
        WB_ADDR_WIDTH'(4) << MEM_DEPTH_LOG2;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [WB_DATA_WIDTH-1:0] mem [DEPTH];

    logic [1:0]                state;
    logic [3:0]                cnt;
    logic [MEM_DEPTH_LOG2-1:0] idx_q;
    logic                      bad_q;
    logic                      we_q;
    logic [WB_DATA_WIDTH-1:0]  dat_q;
    logic [LANES-1:0]          sel_q;

    logic [WB_ADDR_WIDTH-1:0]  offset;
    logic [MEM_DEPTH_LOG2-1:0] idx;
    logic                      bad;

    assign offset = adr & ~ADR_MASK;
    assign idx    = offset[MEM_DEPTH_LOG2+1:2];
    assign bad    = (offset >= MEM_BYTES) || (offset[1:0] != 2'b00);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
            ack   <= 1'b0;
            err   <= 1'b0;
            dat_r <= '0;
            idx_q <= '0;
            bad_q <= 1'b0;
            we_q  <= 1'b0;
            dat_q <= '0;
            sel_q <= '0;
        end else begin
            ack   <= 1'b0;
            err   <= 1'b0;
            dat_r <= '0;
            unique case (state)
                IDLE: begin
                    if (cyc && stb) begin
                        idx_q <= idx;
                        bad_q <= bad;
                        we_q  <= we;
                        dat_q <= dat_w;
                        sel_q <= sel;
                        cnt   <= 4'(WAIT_STATES);
                        state <= (WAIT_STATES > 0) ? WAIT : RESP;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    // Initiator dropped the cycle: abandon silently.
                    if (!cyc) begin
                        state <= IDLE;
                        cnt   <= 4'd0;
                    end else if (cnt == 4'd1) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    // Termination is registered, so it shows in the
                    // cycle after RESP, while the FSM is back in IDLE.
                    state <= IDLE;
                    if (bad_q) begin
                        err <= 1'b1;
                    end else begin
                        ack <= 1'b1;
                        if (!we_q) dat_r <= mem[idx_q];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Array has no reset; write commits at the edge that ends RESP.
    always_ff @(posedge clock) begin
        if (state == RESP && we_q && !bad_q) begin
            for (int i = 0; i < LANES; i++) begin
                if (sel_q[i]) mem[idx_q][8*i +: 8] <= dat_q[8*i +: 8];
            end
        end
    end

endmodule

// File: doc/wb_sram_target.md
WB_SRAM_TARGET -- requirements
Module: wb_sram_target

Interface
REQ-001 SHALL have parameter WB_ADDR_WIDTH, default 32: Wishbone address width.
REQ-002 SHALL have parameter WB_DATA_WIDTH, default 32: Wishbone data width; only 32 is supported.
REQ-003 SHALL have parameter MEM_DEPTH_LOG2, default 10: log2 of the word count of the internal array (1024 x 32 bits).
REQ-004 SHALL have parameter ADR_MASK, default 32'hF000_0000: address bits used for region select upstream; these bits are ignored here.
REQ-005 SHALL have parameter WAIT_STATES, default 1, legal range 0..15: extra cycles inserted before the response.
REQ-006 SHALL have port clock, input, 1: the single clock; all logic is rising-edge.
REQ-007 SHALL have port reset, input, 1: reset, asynchronous assert, active-low.
REQ-008 SHALL have port adr, input, WB_ADDR_WIDTH: byte address.
REQ-009 SHALL have port dat_w, input, WB_DATA_WIDTH: write data.
REQ-010 SHALL have port dat_r, output, WB_DATA_WIDTH: read data.
REQ-011 SHALL have ports cyc, stb, we, inputs, 1 each: Wishbone classic cycle, strobe and write-enable.
REQ-012 SHALL have port sel, input, WB_DATA_WIDTH/8: byte lane enables; bit i covers dat bits [8i+7:8i].
REQ-013 SHALL have ports ack, err, outputs, 1 each: normal and error termination.

Function
REQ-014 SHALL implement a Wishbone classic, registered-response target with states IDLE, WAIT and RESP.
REQ-015 Offset SHALL be adr & ~ADR_MASK, and word index SHALL be offset[MEM_DEPTH_LOG2+1:2].
REQ-016 In IDLE, a request is cyc&stb sampled high; it SHALL latch adr, we, dat_w and sel, then load wait counter = WAIT_STATES.
REQ-017 On accepting a request, the FSM SHALL go to WAIT if WAIT_STATES>0, else to RESP.
REQ-018 In WAIT, the counter SHALL decrement by 1 each cycle; on the cycle it reads 1, the next state SHALL be RESP.
REQ-019 In RESP, exactly one of ack or err SHALL be high for exactly one cycle, and the next state SHALL be IDLE.
REQ-020 Latency: request sampled at edge k -> termination high in the cycle after edge k+1+WAIT_STATES.
REQ-021 Error condition SHALL be: offset >= 4<<MEM_DEPTH_LOG2, or offset[1:0]!=0. On error, err SHALL be driven instead of ack, with no memory write and dat_r=0.
REQ-022 On write (we=1, no error), only bytes with sel[i]=1 SHALL be updated, committed at the edge ending the RESP cycle; sel=0 SHALL still ack, with no change.
REQ-023 On read (we=0, no error), dat_r SHALL equal the full addressed word during the ack cycle, regardless of sel.
REQ-024 dat_r SHALL be 0 in every cycle without read-ack.
REQ-025 Abort: if cyc is low in any WAIT cycle, the FSM SHALL return to IDLE next edge with no ack/err and no write.
REQ-026 Abort: cyc low during RESP SHALL still complete that cycle's write; this is the initiator's responsibility.
REQ-027 Back-to-back: a request is sampled only in IDLE; an stb held high in the cycle after RESP SHALL be treated as a new request.
REQ-028 Inputs outside IDLE SHALL be ignored except cyc, which is used for abort detection.

Reset
REQ-029 When reset is low, the FSM SHALL go to IDLE, the counter to 0, and ack, err and dat_r to 0, asynchronously.
REQ-030 Memory contents SHALL NOT be cleared by reset and are undefined after power-up.
REQ-031 Reset mid-transaction SHALL discard the transaction: no write and no termination.
REQ-032 Reset deassertion SHALL be synchronous to clock; the first request SHALL be accepted no earlier than the first edge with reset high.

Verification
REQ-033 With WAIT_STATES=1: write adr=0x1000_0010, dat_w=0xDEADBEEF, sel=4'hF; then read the same address -> each ack comes 3 edges after the request edge, and the read returns dat_r=0xDEADBEEF.
REQ-034 Partial write: after the REQ-033 write, write sel=4'b0101, dat_w=0x11223344, then read -> 0xDE22BE44.
REQ-035 Errors: a read at offset 0x1000 (depth 1024) -> err for 1 cycle, ack=0, dat_r=0. A write at adr=0x1000_0002 -> err, and the memory is unchanged.
REQ-036 Abort: drop cyc in the WAIT cycle of a write to 0x1000_0020 -> no ack/err, and a later read of that word returns its prior value.
REQ-037 Reset: assert reset low during WAIT -> ack, err and dat_r go to 0 immediately; after release, a fresh read completes normally with no stray ack.
REQ-038 Back-to-back: with WAIT_STATES=0, 8 consecutive reads with stb held high -> one ack every 2 cycles, with correct data for each.
